// File: rtl/square_gen_pkg.sv
// Shared types, default widths and helpers for the square-wave DAC source.
package square_gen_pkg;

    // Generator states: IDLE outputs the low level, RUN walks the phase accumulator.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEF_DAC_WIDTH        = 14;
    localparam int DEF_AXIS_TDATA_WIDTH = 32;
    localparam int DEF_PHASE_WIDTH      = 32;
    localparam int DEF_COUNT_WIDTH      = 32;

    // Sign-extend the low 'width' bits of 'value' to 64 bits; callers truncate
    // the result to their own stream width.
    function automatic logic [63:0] sign_extend(input logic [63:0] value, input int width);
        logic [63:0] mask;
        mask = ~(64'hFFFF_FFFF_FFFF_FFFF << width);
        if (((value >> (width - 32'sd1)) & 64'd1) != 64'd0) begin
            return value | ~mask;
        end else begin
            return value & mask;
        end
    endfunction

endpackage

// File: rtl/square_wave_generator_edge.sv
// Rising-edge detector; also used by the counter-side trigger logic.
module rising_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic pulse
);

    logic in_d_r;

    // Remember the previous sample of the input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_d_r <= 1'b0;
        end else begin
            in_d_r <= in;
        end
    end

    // A pulse is present while the input is high but was low last cycle.
    assign pulse = in & ~in_d_r;

endmodule

// File: rtl/square_wave_generator.sv
// AXI-Stream square-wave source: phase accumulator, programmable levels,
// continuous or N-period burst operation.
module square_wave_generator
    import square_gen_pkg::*;
#(
    parameter int DAC_WIDTH        = DEF_DAC_WIDTH,
    parameter int AXIS_TDATA_WIDTH = DEF_AXIS_TDATA_WIDTH,
    parameter int PHASE_WIDTH      = DEF_PHASE_WIDTH,
    parameter int COUNT_WIDTH      = DEF_COUNT_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [PHASE_WIDTH-1:0]      phase_inc,
    input  logic [DAC_WIDTH-1:0]        high_level,
    input  logic [DAC_WIDTH-1:0]        low_level,
    input  logic [COUNT_WIDTH-1:0]      burst_len,
    input  logic                        trigger,
    input  logic                        stop,
    output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_OUT_tdata,
    output logic                        M_AXIS_OUT_tvalid,
    input  logic                        M_AXIS_OUT_tready,
    output logic                        busy,
    output logic [COUNT_WIDTH-1:0]      period_count
);

    state_t                      state_r, state_nx_s;
    logic [PHASE_WIDTH-1:0]      acc_r, acc_nx_s;
    logic [PHASE_WIDTH-1:0]      sh_inc_r;
    logic [DAC_WIDTH-1:0]        sh_high_r, sh_low_r;
    logic [COUNT_WIDTH-1:0]      sh_burst_r;
    logic [AXIS_TDATA_WIDTH-1:0] tdata_r, tdata_nx_s;
    logic                        tvalid_r;
    logic                        busy_r;
    logic [COUNT_WIDTH-1:0]      pc_r, pc_nx_s, pc_inc_s;
    logic                        capture_s;
    logic                        trig_s;
    logic                        hs_s;
    logic                        carry_s;
    logic [PHASE_WIDTH-1:0]      sum_s;
    logic [AXIS_TDATA_WIDTH-1:0] new_high_s, sh_high_ext_s, sh_low_ext_s;

    rising_edge_detect u_trig_edge (
        .clk   (clk),
        .rst   (rst),
        .in    (trigger),
        .pulse (trig_s)
    );

    assign hs_s             = tvalid_r & M_AXIS_OUT_tready;
    assign {carry_s, sum_s} = {1'b0, acc_r} + {1'b0, sh_inc_r};
    assign pc_inc_s         = (pc_r == {COUNT_WIDTH{1'b1}}) ? pc_r : pc_r + COUNT_WIDTH'(1);
    assign new_high_s       = AXIS_TDATA_WIDTH'(sign_extend(64'(high_level), DAC_WIDTH));
    assign sh_high_ext_s    = AXIS_TDATA_WIDTH'(sign_extend(64'(sh_high_r), DAC_WIDTH));
    assign sh_low_ext_s     = AXIS_TDATA_WIDTH'(sign_extend(64'(sh_low_r), DAC_WIDTH));

    // Next-state, accumulator, sample and period-count decisions; stop beats trig beats RUN stepping.
    always_comb begin
        state_nx_s = state_r;
        acc_nx_s   = acc_r;
        pc_nx_s    = pc_r;
        tdata_nx_s = tdata_r;
        capture_s  = 1'b0;
        if (stop) begin
            state_nx_s = IDLE;
            tdata_nx_s = sh_low_ext_s;
        end else if (trig_s) begin
            capture_s  = 1'b1;
            acc_nx_s   = {PHASE_WIDTH{1'b0}};
            pc_nx_s    = {COUNT_WIDTH{1'b0}};
            state_nx_s = RUN;
            tdata_nx_s = new_high_s;
        end else begin
            case (state_r)
                IDLE: begin
                    tdata_nx_s = sh_low_ext_s;
                end
                RUN: begin
                    if (hs_s) begin
                        acc_nx_s   = sum_s;
                        tdata_nx_s = sum_s[PHASE_WIDTH-1] ? sh_low_ext_s : sh_high_ext_s;
                        if (carry_s) begin
                            pc_nx_s = pc_inc_s;
                            if ((sh_burst_r != {COUNT_WIDTH{1'b0}}) && (pc_inc_s == sh_burst_r)) begin
                                state_nx_s = IDLE;
                                tdata_nx_s = sh_low_ext_s;
                            end else begin
                                state_nx_s = RUN;
                            end
                        end else begin
                            pc_nx_s = pc_r;
                        end
                    end else begin
                        acc_nx_s = acc_r;
                    end
                end
                default: begin
                    state_nx_s = IDLE;
                end
            endcase
        end
    end

    // State, accumulator, stream and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            acc_r    <= {PHASE_WIDTH{1'b0}};
            tdata_r  <= {AXIS_TDATA_WIDTH{1'b0}};
            tvalid_r <= 1'b0;
            busy_r   <= 1'b0;
            pc_r     <= {COUNT_WIDTH{1'b0}};
        end else begin
            state_r  <= state_nx_s;
            acc_r    <= acc_nx_s;
            tdata_r  <= tdata_nx_s;
            tvalid_r <= 1'b1;
            busy_r   <= (state_nx_s == RUN);
            pc_r     <= pc_nx_s;
        end
    end

    // Shadow copies of the configuration, loaded only on an accepted trigger edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_inc_r   <= {PHASE_WIDTH{1'b0}};
            sh_high_r  <= {DAC_WIDTH{1'b0}};
            sh_low_r   <= {DAC_WIDTH{1'b0}};
            sh_burst_r <= {COUNT_WIDTH{1'b0}};
        end else if (capture_s) begin
            sh_inc_r   <= phase_inc;
            sh_high_r  <= high_level;
            sh_low_r   <= low_level;
            sh_burst_r <= burst_len;
        end else begin
            sh_inc_r   <= sh_inc_r;
            sh_high_r  <= sh_high_r;
            sh_low_r   <= sh_low_r;
            sh_burst_r <= sh_burst_r;
        end
    end

    assign M_AXIS_OUT_tdata  = tdata_r;
    assign M_AXIS_OUT_tvalid = tvalid_r;
    assign busy              = busy_r;
    assign period_count      = pc_r;

endmodule

// File: tb/tb_square_wave_generator.sv
// Self-checking bench for square_wave_generator: behavioural model plus
// hand-computed scenario checks and a randomized phase.
module tb_square_wave_generator;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] phase_inc;
    logic [13:0] high_level, low_level;
    logic [31:0] burst_len;
    logic        trigger, stop, tready;
    logic [31:0] tdata;
    logic        tvalid, busy;
    logic [31:0] period_count;

    int n_cmp  = 0;
    int n_fail = 0;

    square_wave_generator dut (
        .clk               (clk),
        .rst               (rst),
        .phase_inc         (phase_inc),
        .high_level        (high_level),
        .low_level         (low_level),
        .burst_len         (burst_len),
        .trigger           (trigger),
        .stop              (stop),
        .M_AXIS_OUT_tdata  (tdata),
        .M_AXIS_OUT_tvalid (tvalid),
        .M_AXIS_OUT_tready (tready),
        .busy              (busy),
        .period_count      (period_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ext(input logic [13:0] v);
        return 32'($signed(v));
    endfunction

    // ---------------- behavioural model ----------------
    // The run is described by n, the number of accepted samples since the
    // trigger: phase = n*inc mod 2^32, periods = floor(n*inc / 2^32).
    logic        m_run, m_tvalid, m_trig_d;
    longint unsigned m_n;
    logic [31:0] m_inc, m_burst, m_pc, m_tdata;
    logic [13:0] m_hi, m_lo;

    logic        nx_run;
    longint unsigned nx_n;
    logic [31:0] nx_inc, nx_burst, nx_pc, nx_tdata;
    logic [13:0] nx_hi, nx_lo;
    logic [63:0] total;

    always_comb begin
        nx_run   = m_run;
        nx_n     = m_n;
        nx_inc   = m_inc;
        nx_burst = m_burst;
        nx_pc    = m_pc;
        nx_tdata = m_tdata;
        nx_hi    = m_hi;
        nx_lo    = m_lo;
        total    = 64'd0;
        if (stop) begin
            nx_run   = 1'b0;
            nx_tdata = ext(m_lo);
        end else if (trigger && !m_trig_d) begin
            nx_inc   = phase_inc;
            nx_hi    = high_level;
            nx_lo    = low_level;
            nx_burst = burst_len;
            nx_n     = 0;
            nx_pc    = 32'd0;
            nx_run   = 1'b1;
            nx_tdata = ext(high_level);
        end else if (m_run) begin
            if (m_tvalid && tready) begin
                nx_n     = m_n + 1;
                total    = nx_n * {32'd0, m_inc};
                nx_pc    = total[63:32];
                nx_tdata = total[31] ? ext(m_lo) : ext(m_hi);
                if (m_burst != 32'd0 && nx_pc == m_burst) begin
                    nx_run   = 1'b0;
                    nx_tdata = ext(m_lo);
                end
            end
        end else begin
            nx_tdata = ext(m_lo);
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_run <= 1'b0; m_tvalid <= 1'b0; m_trig_d <= 1'b0; m_n <= 0;
            m_inc <= 32'd0; m_burst <= 32'd0; m_pc <= 32'd0; m_tdata <= 32'd0;
            m_hi <= 14'd0; m_lo <= 14'd0;
        end else begin
            m_run <= nx_run; m_tvalid <= 1'b1; m_trig_d <= trigger; m_n <= nx_n;
            m_inc <= nx_inc; m_burst <= nx_burst; m_pc <= nx_pc; m_tdata <= nx_tdata;
            m_hi <= nx_hi; m_lo <= nx_lo;
        end
    end

    // Compare DUT outputs with the model every cycle, away from the active edge.
    always @(negedge clk) begin
        check("model_tdata", 64'(tdata), 64'(m_tdata));
        check("model_tvalid", 64'(tvalid), 64'(m_tvalid));
        check("model_busy", 64'(busy), 64'(m_run));
        check("model_period_count", 64'(period_count), 64'(m_pc));
    end

    // ---------------- loopback frequency counter ----------------
    logic lb_clear = 1'b0;
    logic lb_above;
    int   lb_count;

    // Counts rising crossings of the sample stream with hysteresis around zero.
    always @(negedge clk) begin
        if (lb_clear) begin
            lb_above <= 1'b0;
            lb_count <= 0;
        end else if (!lb_above && $signed(tdata) > 32'sd500) begin
            lb_above <= 1'b1;
            lb_count <= lb_count + 1;
        end else if (lb_above && $signed(tdata) < -32'sd500) begin
            lb_above <= 1'b0;
        end
    end

    // ---------------- stimulus ----------------
    logic [31:0] lit [4];
    int cyc;

    initial begin
        lit[0] = 32'd1000; lit[1] = 32'd1000; lit[2] = 32'hFFFFFC18; lit[3] = 32'hFFFFFC18;
        rst = 1'b0; trigger = 1'b0; stop = 1'b0; tready = 1'b1;
        phase_inc = 32'd0; high_level = 14'd0; low_level = 14'd0; burst_len = 32'd0;
        #1 rst = 1'b1;
        #2;
        check("reset_tdata", 64'(tdata), 64'd0);
        check("reset_tvalid", 64'(tvalid), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_period_count", 64'(period_count), 64'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("tvalid_after_reset", 64'(tvalid), 64'd1);

        // Continuous run, quarter-period steps.
        phase_inc = 32'h4000_0000; high_level = 14'd1000; low_level = 14'h3C18; burst_len = 32'd0;
        trigger = 1'b1;
        for (int j = 0; j <= 8; j++) begin
            @(negedge clk);
            check("cont_tdata", 64'(tdata), 64'(lit[j % 4]));
            check("cont_pc", 64'(period_count), 64'(j / 4));
            check("cont_busy", 64'(busy), 64'd1);
        end

        // Backpressure for five cycles during the high half.
        tready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("bp_tdata_hold", 64'(tdata), 64'd1000);
            check("bp_pc_hold", 64'(period_count), 64'd2);
        end
        tready = 1'b1;
        @(negedge clk);
        check("bp_resume_0", 64'(tdata), 64'd1000);
        @(negedge clk);
        check("bp_resume_1", 64'(tdata), 64'hFFFFFC18);
        check("bp_resume_pc", 64'(period_count), 64'd2);

        // stop together with a trigger edge: stop wins.
        trigger = 1'b0;
        @(negedge clk);
        stop = 1'b1; trigger = 1'b1;
        @(negedge clk);
        check("stop_busy", 64'(busy), 64'd0);
        check("stop_tdata", 64'(tdata), 64'hFFFFFC18);
        check("stop_pc_held", 64'(period_count), 64'd2);
        stop = 1'b0; trigger = 1'b0;
        @(negedge clk);
        check("stop_idle_pc", 64'(period_count), 64'd2);
        trigger = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k == 0) begin
                check("restart_pc", 64'(period_count), 64'd0);
                check("restart_busy", 64'(busy), 64'd1);
                check("restart_tdata", 64'(tdata), 64'd1000);
            end
        end
        check("held_trigger_pc", 64'(period_count), 64'd4);
        check("held_trigger_tdata", 64'(tdata), 64'hFFFFFC18);
        trigger = 1'b0;

        // Three-period burst restarted from RUN.
        burst_len = 32'd3;
        @(negedge clk);
        trigger = 1'b1;
        for (int j = 0; j <= 12; j++) begin
            @(negedge clk);
            if (j == 11) check("burst_busy_before_end", 64'(busy), 64'd1);
        end
        check("burst_end_busy", 64'(busy), 64'd0);
        check("burst_end_tdata", 64'(tdata), 64'hFFFFFC18);
        check("burst_end_pc", 64'(period_count), 64'd3);
        repeat (3) @(negedge clk);
        check("burst_pc_held", 64'(period_count), 64'd3);
        trigger = 1'b0; burst_len = 32'd0;

        // Asynchronous reset in the middle of a run.
        @(negedge clk);
        trigger = 1'b1;
        repeat (6) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_tdata", 64'(tdata), 64'd0);
        check("midrst_tvalid", 64'(tvalid), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_pc", 64'(period_count), 64'd0);
        @(negedge clk);
        rst = 1'b0; trigger = 1'b0;
        #1 check("rel_tvalid_low", 64'(tvalid), 64'd0);
        @(posedge clk);
        #1 check("rel_tvalid_high", 64'(tvalid), 64'd1);

        // Loopback into a threshold counter with random backpressure.
        phase_inc = 32'h1000_0000; burst_len = 32'd100;
        high_level = 14'd1000; low_level = 14'h3C18;
        lb_clear = 1'b1;
        @(negedge clk); @(negedge clk);
        lb_clear = 1'b0; trigger = 1'b1;
        @(negedge clk);
        cyc = 0;
        while (busy && cyc < 4000) begin
            tready = ($urandom % 4) != 0;
            @(negedge clk);
            cyc++;
        end
        check("loopback_timeout", 64'(cyc < 4000), 64'd1);
        tready = 1'b1; trigger = 1'b0;
        repeat (3) @(negedge clk);
        check("loopback_count", 64'(lb_count), 64'd100);
        check("loopback_pc", 64'(period_count), 64'd100);

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            tready     = ($urandom % 4) != 0;
            stop       = ($urandom % 64) == 0;
            trigger    = ($urandom % 8) == 0 ? ~trigger : trigger;
            phase_inc  = (($urandom % 8) == 0) ? 32'd0 : $urandom;
            high_level = 14'($urandom);
            low_level  = 14'($urandom);
            burst_len  = 32'($urandom_range(0, 5));
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/square_wave_generator.md
Name: square_wave_generator

Overview:
- AXI-Stream DAC source that produces a square wave at a programmed frequency, with programmable high and low levels.
- Uses a phase accumulator and supports continuous or N-period burst modes.
- It is the transmit-side counterpart of the ADC-side frequency counter; on loopback, the counter reads back the number of periods emitted.
- Sits between the PS-configured GPIO registers and the DAC AXIS input.

Parameters:
- DAC_WIDTH, 14, DAC sample width (two's complement).
- AXIS_TDATA_WIDTH, 32, output stream width; the sample is sign-extended to this width.
- PHASE_WIDTH, 32, phase accumulator width. f_out = phase_inc * f_clk / 2^PHASE_WIDTH.
- COUNT_WIDTH, 32, width of the burst length and the period counter.

Ports:
- clk  in  1  sample clock, 125 MHz. The block uses one clock only.
- rst  in  1  asynchronous, active-high reset.
- phase_inc  in  PHASE_WIDTH  frequency word, captured on a trigger edge.
- high_level  in  DAC_WIDTH  signed level for the first half-period, captured on a trigger edge.
- low_level  in  DAC_WIDTH  signed level for the second half-period and for idle, captured on a trigger edge.
- burst_len  in  COUNT_WIDTH  periods per burst; 0 means continuous. Captured on a trigger edge.
- trigger  in  1  a rising edge starts or restarts generation.
- stop  in  1  level input; while high it forces IDLE.
- M_AXIS_OUT_tdata  out  AXIS_TDATA_WIDTH  DAC sample.
- M_AXIS_OUT_tvalid  out  1  sample valid.
- M_AXIS_OUT_tready  in  1  downstream ready.
- busy  out  1  high while in RUN.
- period_count  out  COUNT_WIDTH  full periods emitted since the last trigger edge.

Behaviour:
- Reset (asynchronous, active-high) sets:
  - state = IDLE, acc = 0, shadow registers = 0, trigger_d = 0;
  - tdata = 0, tvalid = 0, busy = 0, period_count = 0.
- tvalid goes to 1 on the first clk edge after rst deasserts and then stays 1.
- Trigger edge: trig = trigger & ~trigger_d, where trigger_d is trigger registered on clk.
  - Holding trigger high produces a single edge.
- States are IDLE and RUN.
- IDLE:
  - tdata = sign-extended shadow low_level.
  - acc is held.
  - A trig with stop low captures all four inputs into the shadow registers, then on the same edge sets acc = 0, period_count = 0, state = RUN, and tdata = new high_level.
- RUN:
  - A handshake is tvalid & tready at a clk edge.
  - On each handshake: acc_next = acc + shadow_phase_inc, taken modulo 2^PHASE_WIDTH.
  - tdata = high level if acc_next[MSB] == 0, otherwise low level.
- Latency: the sample for an accumulator value appears on the edge that loads that value. The first RUN sample is on the trig edge itself.
- Backpressure: while tready = 0, tdata, acc, period_count and state hold. Only stop, trig and reset act.
- Wrap: a carry out of acc + inc on a handshake means one period has completed, and period_count increments.
  - period_count saturates at 2^COUNT_WIDTH - 1.
- Burst end: if shadow_burst_len != 0 and a wrap makes period_count equal shadow_burst_len, then on that edge:
  - state = IDLE, busy = 0, tdata = low level;
  - period_count keeps the final value until the next trig.
- Restart: trig in RUN re-captures the inputs and restarts exactly as from IDLE, even mid-period.
- stop = 1: on the next edge, state = IDLE and tdata = low level; period_count is held.
  - stop and trig together: stop wins and the trig is discarded.
- phase_inc = 0: the output stays at high_level forever, with no wraps. In burst mode with burst_len != 0 it never ends until stop or trig.
- Inputs are sampled only on trig edges. Changes during RUN have no effect.
- Reset mid-burst: immediate IDLE and all-zero outputs. tvalid is 0 until the first edge after reset release.

Decomposition:
- Package square_gen_pkg holds:
  - state enum {IDLE, RUN};
  - default widths;
  - the helper function for sign-extending DAC_WIDTH to AXIS_TDATA_WIDTH.
- One sub-module, rising_edge_detect (clk, rst, in, pulse). It is shared with the counter-side trigger logic.

Test Plan:
1. Phase and burst 0:
   - Stimulus: phase_inc = 2^30, high = 1000, low = -1000, burst_len = 0, tready = 1, trig.
   - Required: tdata repeats 1000, 1000, -1000, -1000; period_count increments every 4 handshakes; busy = 1.
2. Burst end:
   - Stimulus: same as scenario 1 with burst_len = 3.
   - Required: after 12 handshakes, state = IDLE, tdata = -1000 (0xFFFFFC18), busy = 0, period_count = 3 held.
3. Backpressure:
   - Stimulus: in scenario 1, drop tready for 5 cycles mid-high.
   - Required: tdata and period_count frozen; the sequence resumes without a lost or duplicated sample.
4. stop and trig together:
   - Stimulus: assert stop and trigger edge in the same cycle during RUN.
   - Required: IDLE next edge, tdata = low, period_count held.
   - Then: trigger held high for 20 cycles with stop low gives exactly one restart, with period_count = 0.
5. Reset mid-run:
   - Stimulus: async rst pulse mid-run, between clk edges.
   - Required: outputs zero immediately with tvalid = 0; tvalid = 1 one edge after release.
6. Loopback:
   - Stimulus: output into the frequency counter with thresholds straddling 0, phase_inc = 2^28, burst_len = 100.
   - Required: the counter reads 100.
